// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritises exceptions and unmasked IRQs, flushes the pipeline,
// captures EPC/cause, pulses exception/rfe to the status register and redirects fetch.
module exc_ctrl #(
  parameter int          N_IRQ     = 4,
  parameter int          FLUSH_CYC = 2,
  parameter logic [31:0] VEC_ADDR  = 32'h0000_0080
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             ill_inst,
  input  logic             syscall,
  input  logic             ovf,
  input  logic [31:0]      exc_pc,
  input  logic             rfe_req,
  input  logic             IE_c,
  input  logic             s_u_c,
  output logic             exception,
  output logic             rfe,
  output logic             flush,
  output logic             pc_load,
  output logic [31:0]      pc_target,
  output logic [31:0]      epc,
  output logic [4:0]       cause,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_VECTOR  = 3'd2,
    S_HANDLER = 3'd3,
    S_RFE     = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] epc_d, pc_target_d;
  logic [4:0]  cause_d, ev_code, irq_code;
  logic        ev_valid, irq_any;
  logic        exception_d, rfe_d, flush_d, pc_load_d, busy_d;
  logic        s_u_unused;

  // Mode bit does not affect sequencing; user and supervisor syscalls are handled alike.
  assign s_u_unused = s_u_c;
  assign state_dbg  = state;

  // Lowest-numbered IRQ wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    irq_code = 5'h10;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (irq[k]) irq_code = 5'(16 + k);
    end
    irq_any = |irq;
  end

  always_comb begin
    ev_valid = 1'b1;
    ev_code  = 5'h00;
    if (ill_inst)            ev_code = 5'h01;
    else if (syscall)        ev_code = 5'h02;
    else if (ovf)            ev_code = 5'h03;
    else if (IE_c && irq_any) ev_code = irq_code;
    else                     ev_valid = 1'b0;
  end

  // Handshake: every input is a level sampled on each rising edge; an event is taken in the
  // cycle it is seen in IDLE/HANDLER and ignored in every other state. Outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      epc       <= 32'd0;
      cause     <= 5'd0;
      exception <= 1'b0;
      rfe       <= 1'b0;
      flush     <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= 32'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      epc       <= epc_d;
      cause     <= cause_d;
      exception <= exception_d;
      rfe       <= rfe_d;
      flush     <= flush_d;
      pc_load   <= pc_load_d;
      pc_target <= pc_target_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    epc_d   = epc;
    cause_d = cause;
    case (state)
      S_IDLE, S_HANDLER: begin
        if (ev_valid) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_INIT;
          epc_d   = exc_pc;
          cause_d = ev_code;
        end else if (rfe_req && state == S_HANDLER) begin
          state_d = S_RFE;
        end
      end
      S_FLUSH: begin
        if (cnt == 4'd0) state_d = S_VECTOR;
        else             cnt_d   = cnt - 4'd1;
      end
      S_VECTOR: state_d = S_HANDLER;
      S_RFE:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    exception_d = (state_d == S_VECTOR);
    rfe_d       = (state_d == S_RFE);
    pc_load_d   = (state_d == S_VECTOR) || (state_d == S_RFE);
    flush_d     = (state_d == S_FLUSH) || pc_load_d;
    busy_d      = flush_d;
    pc_target_d = pc_target;
    if (state_d == S_VECTOR)   pc_target_d = VEC_ADDR;
    else if (state_d == S_RFE) pc_target_d = epc_d;
  end

endmodule
